alu_issue_seq: RTL and testbench

- Upstream issue/writeback stage for the registered N-bit ALU (MOV/NOT/ADD/SUB/OR/AND/SLT via 3-bit ALUOp, one-cycle registered result and carry).
- Buffers 13-bit instructions in a small FIFO, reads operands from a local register file and drives the ALU operand, op and carry-in inputs.
- Captures the ALU result and carry one cycle later, then writes back the destination register and the carry flag.
- Instructions are fully serialised, so there is no data hazard.

---
 rtl/alu_issue_seq_if.sv | 24 ++
 rtl/alu_issue_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_seq_if.sv
// Instruction handshake and ALU operand/result bus between alu_issue_seq and the registered ALU.
interface alu_issue_seq_if #(
    parameter int unsigned N = 32
) ();
    logic          instr_valid;
    logic [12:0]   instr;
    logic          instr_ready;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic          alu_cin;
    logic [N-1:0]  alu_result;
    logic          alu_cout;

    modport slave (
        input  instr_valid, instr, alu_result, alu_cout,
        output instr_ready, alu_a, alu_b, alu_op, alu_cin
    );

    modport master (
        output instr_valid, instr, alu_result, alu_cout,
        input  instr_ready, alu_a, alu_b, alu_op, alu_cin
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Serialising issue/writeback sequencer for a registered ALU: FIFO -> operand read -> EXEC -> WB.
// Optional retire counter output enabled by defining ALU_SEQ_PERF_CNT_EN.
module alu_issue_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned NREG  = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_seq_if.slave bus,
    output logic           cflag,
    output logic           busy,
    output logic           retire,
    input  logic [2:0]     dbg_addr,
    output logic [N-1:0]   dbg_data
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]    retire_cnt
`endif
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RA_W  = $clog2(NREG);
    localparam logic [2:0]  OP_NOP = 3'b111;

    typedef struct packed {
        logic       use_carry;
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
    } instr_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t             state_q, state_d;
    instr_t             fifo_q [DEPTH];
    instr_t             fifo_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       rf_q [NREG];
    logic [N-1:0]       rf_d [NREG];
    logic               cflag_q, cflag_d;
    logic [N-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               alu_cin_q, alu_cin_d;
    logic [2:0]         rd_q, rd_d;
    logic               retire_q, retire_d;
    logic               full, empty, push, pop;
    instr_t             head;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = bus.instr_valid && !full;
    assign head  = fifo_q[rd_ptr_q];

    assign bus.instr_ready = !full;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_cin     = alu_cin_q;
    assign cflag           = cflag_q;
    assign retire          = retire_q;
    assign busy            = !empty || (state_q != S_IDLE);
    assign dbg_data        = (dbg_addr == 3'd0) ? '0 : rf_q[RA_W'(dbg_addr)];

    // Next-state: FIFO bookkeeping, operand issue from IDLE, writeback in WB.
    always_comb begin
        state_d   = state_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rf_d      = rf_q;
        cflag_d   = cflag_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_cin_d = alu_cin_q;
        rd_d      = rd_q;
        retire_d  = 1'b0;
        pop       = 1'b0;

        if (push) begin
            fifo_d[wr_ptr_q] = instr_t'(bus.instr);
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    alu_a_d   = (head.rs == 3'd0) ? '0 : rf_q[RA_W'(head.rs)];
                    alu_b_d   = (head.rt == 3'd0) ? '0 : rf_q[RA_W'(head.rt)];
                    alu_op_d  = head.op;
                    alu_cin_d = head.use_carry & cflag_q;
                    rd_d      = head.rd;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                retire_d = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                // NOP still spends its WB slot but leaves architectural state alone.
                if (alu_op_q != OP_NOP) begin
                    if (rd_q != 3'd0) rf_d[RA_W'(rd_q)] = bus.alu_result;
                    cflag_d = bus.alu_cout;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
            cflag_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_cin_q <= 1'b0;
            rd_q      <= '0;
            retire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            fifo_q    <= fifo_d;
            rf_q      <= rf_d;
            cflag_q   <= cflag_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_cin_q <= alu_cin_d;
            rd_q      <= rd_d;
            retire_q  <= retire_d;
        end
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Counts every WB edge, NOPs included; wraps naturally.
    always_comb begin
        retire_cnt_d = retire_cnt_q + 16'(state_q == S_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: directed instructions, a bench-side registered ALU, retire monitor.
module tb_alu_issue_seq;
    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cflag, busy, retire;
    logic [2:0]    dbg_addr;
    logic [2:0]    main_addr = 3'd0;
    logic [2:0]    mon_addr = 3'd0;
    logic          mon_active = 1'b0;
    logic [N-1:0]  dbg_data;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0]   retire_cnt;
`endif

    always #5 clk = ~clk;

    alu_issue_seq_if #(.N(N)) bus ();

    alu_issue_seq #(.N(N), .NREG(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cflag    (cflag),
        .busy     (busy),
        .retire   (retire),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    assign dbg_addr = mon_active ? mon_addr : main_addr;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic         cin;
        logic [2:0]   rd;
        logic [N-1:0] rdval;
        logic         c;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    int            checks = 0;
    int            failures = 0;
    int            n_ret = 0;
    int            cyc = 0;
    int            ret_cyc[$];
    logic [N-1:0]  m_reg [8];
    logic          m_c;

    // Bench ALU: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110 SLT, 111 XOR.
    function automatic logic [N:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op, input logic cin);
        case (op)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, ~a};
            3'd2:    return {1'b0, a} + {1'b0, b} + 33'(cin);
            3'd3:    return {1'b0, a} + {1'b0, ~b} + 33'(1);
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a & b};
            3'd6:    return 33'($signed(a) < $signed(b));
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        {bus.alu_cout, bus.alu_result} <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);
        cyc <= cyc + 1;
    end

    function automatic logic [12:0] mk(input logic uc, input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {uc, op, rd, rs, rt};
    endfunction

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [12:0] ins, output int waited);
        int         n = 0;
        exp_t       e;
        logic [N:0] r;
        @(negedge clk);
        while (!bus.instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!bus.instr_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: instr_ready stuck low for %0d cycles", n);
            return;
        end
        e.a   = m_reg[ins[5:3]];
        e.b   = m_reg[ins[2:0]];
        e.op  = ins[11:9];
        e.cin = ins[12] & m_c;
        r     = alu_f(e.a, e.b, e.op, e.cin);
        if (e.op != 3'b111) begin
            if (ins[8:6] != 3'd0) m_reg[ins[8:6]] = r[N-1:0];
            m_c = r[N];
        end
        e.rd    = ins[8:6];
        e.rdval = m_reg[ins[8:6]];
        e.c     = m_c;
        sbq.push_back(e);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || mon_active || sbq.size() != 0) && n < 200);
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, sbq.size());
        end
        @(negedge clk);
    endtask

    task automatic rdreg(input string name, input logic [2:0] a, input logic [N-1:0] exp);
        main_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_c = 1'b0;
    endtask

    // Monitor: on each retire, check issued operands, then the writeback one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && retire) begin
                ret_cyc.push_back(cyc);
                n_ret++;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got retire=1 expected no pending instruction");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("wb_alu_a", bus.alu_a, mon_e.a);
                    chk("wb_alu_b", bus.alu_b, mon_e.b);
                    chk("wb_alu_op", 32'(bus.alu_op), 32'(mon_e.op));
                    chk("wb_alu_cin", 32'(bus.alu_cin), 32'(mon_e.cin));
                    mon_addr   = mon_e.rd;
                    mon_active = 1'b1;
                    @(negedge clk);
                    chk("wb_reg", dbg_data, mon_e.rdval);
                    chk("wb_cflag", 32'(cflag), 32'(mon_e.c));
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        int waits[7];
        int n;
        int ret_base;
        logic [12:0] burst[7];

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #20;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(bus.instr_ready), 32'(1));
        chk("rst_retire", 32'(retire), 32'(0));
        chk("rst_alu_a", bus.alu_a, '0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(0));
        chk("rst_cflag", 32'(cflag), 32'(0));
        for (int i = 1; i < 8; i++) rdreg("rst_reg", 3'(i), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // MOV r1,r0: retire on the third cycle after the push edge
        push(mk(0, 3'd0, 3'd1, 3'd0, 3'd0), w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < 10);
        chk("t1_retire_latency", 32'(n), 32'(3));
        wait_idle();
        rdreg("t1_r1", 3'd1, 32'h0);
        chk("t1_cflag", 32'(cflag), 32'(0));

        // r1=~0, r2=0-r1=1, r3=r1+r2 -> 0 with carry out
        push(mk(0, 3'd1, 3'd1, 3'd0, 3'd0), w);
        push(mk(0, 3'd3, 3'd2, 3'd0, 3'd1), w);
        push(mk(0, 3'd2, 3'd3, 3'd1, 3'd2), w);
        wait_idle();
        rdreg("t2_r1", 3'd1, 32'hFFFF_FFFF);
        rdreg("t2_r2", 3'd2, 32'h1);
        rdreg("t2_r3", 3'd3, 32'h0);
        chk("t2_cflag", 32'(cflag), 32'(1));

        // ADD r4=r0+r0 with carry-in from cflag
        push(mk(1, 3'd2, 3'd4, 3'd0, 3'd0), w);
        @(negedge clk);
        @(negedge clk);
        chk("t3_exec_cin", 32'(bus.alu_cin), 32'(1));
        chk("t3_exec_op", 32'(bus.alu_op), 32'(2));
        wait_idle();
        rdreg("t3_r4", 3'd4, 32'h1);
        chk("t3_cflag", 32'(cflag), 32'(0));

        // Back-to-back burst: FIFO fills, 7th push stalls two cycles
        burst[0] = mk(0, 3'd2, 3'd5, 3'd2, 3'd2);
        burst[1] = mk(0, 3'd2, 3'd5, 3'd5, 3'd2);
        burst[2] = mk(0, 3'd2, 3'd6, 3'd5, 3'd5);
        burst[3] = mk(0, 3'd4, 3'd7, 3'd6, 3'd2);
        burst[4] = mk(0, 3'd5, 3'd6, 3'd7, 3'd5);
        burst[5] = mk(0, 3'd3, 3'd7, 3'd7, 3'd6);
        burst[6] = mk(0, 3'd0, 3'd5, 3'd7, 3'd0);
        ret_cyc.delete();
        for (int i = 0; i < 7; i++) push(burst[i], waits[i]);
        for (int i = 0; i < 6; i++) chk("t4_no_stall", 32'(waits[i]), 32'(0));
        chk("t4_full_stall", 32'(waits[6]), 32'(2));
        wait_idle();
        chk("t4_retire_count", 32'(ret_cyc.size()), 32'(7));
        for (int i = 1; i < ret_cyc.size(); i++)
            chk("t4_retire_gap", 32'(ret_cyc[i] - ret_cyc[i-1]), 32'(3));
        rdreg("t4_r5", 3'd5, 32'd4);
        rdreg("t4_r6", 3'd6, 32'd3);
        rdreg("t4_r7", 3'd7, 32'd4);
        chk("t4_cflag", 32'(cflag), 32'(0));

        // Write to r0 discarded; NOP leaves r2 and cflag alone
        ret_base = n_ret;
        push(mk(0, 3'd0, 3'd0, 3'd1, 3'd0), w);
        push(mk(0, 3'd2, 3'd3, 3'd1, 3'd2), w);
        push(mk(0, 3'd7, 3'd2, 3'd1, 3'd1), w);
        push(mk(0, 3'd0, 3'd6, 3'd0, 3'd0), w);
        wait_idle();
        chk("t5_retires", 32'(n_ret - ret_base), 32'(4));
        rdreg("t5_r2", 3'd2, 32'h1);
        rdreg("t5_r6_from_r0", 3'd6, 32'h0);
        chk("t5_cflag", 32'(cflag), 32'(0));
        rdreg("t5_r3", 3'd3, 32'h0);

        // Reset during EXEC of NOT r5 drops the writeback
        push(mk(0, 3'd1, 3'd5, 3'd0, 3'd0), w);
        @(negedge clk);
        @(negedge clk);
        chk("t6_exec_op", 32'(bus.alu_op), 32'(1));
        chk("t6_exec_retire", 32'(retire), 32'(0));
        rst_n = 1'b0;
        sbq.delete();
        model_reset();
        #3;
        chk("t6_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_ready", 32'(bus.instr_ready), 32'(1));
        rdreg("t6_r5", 3'd5, 32'h0);
        chk("t6_cflag", 32'(cflag), 32'(0));
        chk("t6_alu_op", 32'(bus.alu_op), 32'(0));
        ret_base = n_ret;
        repeat (4) @(negedge clk);
        chk("t6_no_retire", 32'(n_ret - ret_base), 32'(0));
        push(mk(0, 3'd1, 3'd3, 3'd0, 3'd0), w);
        wait_idle();
        rdreg("t6_r3_after", 3'd3, 32'hFFFF_FFFF);
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("perf_retire_cnt", 32'(retire_cnt), 32'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
